clock_mode_controller: RTL and testbench

Mode and alarm sequencer for the binary clock core. It turns debounced front-panel buttons into the core's hour/minute increment requests and its `set_alarm` level. It compares the running time against the stored alarm and drives the buzzer with ring, snooze and timeout sequencing. It sits between the button debouncers and the clock core, and feeds the display mux with the current mode.

---
 rtl/clock_mode_controller_if.sv | 40 ++++
 rtl/clock_mode_controller.sv | 191 +++++++++++++++++++
 tb/tb_clock_mode_controller.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_mode_controller_if.sv
// Signal bundle between the binary clock core / front panel and clock_mode_controller.
// The controller takes the slave view; the core/panel side takes the master view.
interface clock_mode_controller_if;
  logic       tick_1Hz;
  logic       btn_mode;
  logic       btn_hr;
  logic       btn_min;
  logic       btn_snooze;
  logic       alarm_sw;
  logic [3:0] hr_10s;
  logic [3:0] hr_1s;
  logic [3:0] min_10s;
  logic [3:0] min_1s;
  logic [3:0] sec_10s;
  logic [3:0] sec_1s;
  logic [3:0] alarm_hr_10s;
  logic [3:0] alarm_hr_1s;
  logic [3:0] alarm_min_10s;
  logic [3:0] alarm_min_1s;
  logic       inc_hr;
  logic       inc_min;
  logic       set_alarm;
  logic [1:0] mode;
  logic       buzzer;
  logic       alarm_led;

  modport master (
    output tick_1Hz, btn_mode, btn_hr, btn_min, btn_snooze, alarm_sw,
    output hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s,
    output alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
    input  inc_hr, inc_min, set_alarm, mode, buzzer, alarm_led
  );

  modport slave (
    input  tick_1Hz, btn_mode, btn_hr, btn_min, btn_snooze, alarm_sw,
    input  hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s,
    input  alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
    output inc_hr, inc_min, set_alarm, mode, buzzer, alarm_led
  );
endinterface

// File: rtl/clock_mode_controller.sv
// Mode/alarm sequencer for the binary clock: button edges -> increment requests, alarm ring/snooze.
// Optional snooze state is built only when CLOCK_SNOOZE_EN is defined.
module clock_mode_controller #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300
) (
  input logic                    clk_100MHz,
  input logic                    reset_n,
  clock_mode_controller_if.slave bus
);

  localparam logic [15:0] RingLast = 16'(RING_SECONDS - 1);
`ifdef CLOCK_SNOOZE_EN
  localparam logic [15:0] SnoozeLast = 16'(SNOOZE_SECONDS - 1);
`else
  localparam int unsigned unused_snooze_seconds = SNOOZE_SECONDS;
`endif

  typedef enum logic [1:0] {
    MRun      = 2'b00,
    MSetTime  = 2'b01,
    MSetAlarm = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    AIdle   = 2'b00,
    ARing   = 2'b01
`ifdef CLOCK_SNOOZE_EN
    , ASnooze = 2'b10
`endif
  } alarm_e;

  function automatic logic alarm_active(alarm_e s);
`ifdef CLOCK_SNOOZE_EN
    return (s == ARing) || (s == ASnooze);
`else
    return (s == ARing);
`endif
  endfunction

  // Bit order: tick, mode, hr, min, snooze, alarm_sw
  logic [5:0] async_in;
  logic [5:0] sync1_q, sync2_q;
  logic [5:1] sync3_q;
  logic [5:1] rise;
  logic       tick_rise, mode_rise, snooze_rise, tick_lvl, sw_lvl;
  logic [1:0] req_rise;

  assign async_in    = {bus.tick_1Hz, bus.btn_mode, bus.btn_hr, bus.btn_min,
                        bus.btn_snooze, bus.alarm_sw};
  assign rise        = sync2_q[5:1] & ~sync3_q;
  assign tick_rise   = rise[5];
  assign mode_rise   = rise[4];
  assign req_rise    = rise[3:2];
  assign snooze_rise = rise[1];
  assign tick_lvl    = sync2_q[5];
  assign sw_lvl      = sync2_q[0];

  mode_e             mode_q, mode_d;
  alarm_e            alarm_q, alarm_d;
  logic [15:0]       acnt_q, acnt_d;
  logic [1:0]        inc_q, inc_d;
  logic [1:0][2:0]   age_q, age_d;
  logic              set_alarm_q, set_alarm_d;
  logic              buzzer_q, buzzer_d;
  logic              led_q, led_d;
  logic              mode_change;
  logic              time_match;

  assign time_match = (bus.hr_10s == bus.alarm_hr_10s) && (bus.hr_1s == bus.alarm_hr_1s) &&
                      (bus.min_10s == bus.alarm_min_10s) && (bus.min_1s == bus.alarm_min_1s) &&
                      (bus.sec_10s == 4'd0) && (bus.sec_1s == 4'd0);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      mode_q      <= MRun;
      alarm_q     <= AIdle;
      acnt_q      <= '0;
      inc_q       <= '0;
      age_q       <= '0;
      set_alarm_q <= 1'b0;
      buzzer_q    <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      sync1_q     <= async_in;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q[5:1];
      mode_q      <= mode_d;
      alarm_q     <= alarm_d;
      acnt_q      <= acnt_d;
      inc_q       <= inc_d;
      age_q       <= age_d;
      set_alarm_q <= set_alarm_d;
      buzzer_q    <= buzzer_d;
      led_q       <= led_d;
    end
  end

  // A mode press while the alarm is sounding or snoozing only silences it.
  always_comb begin
    mode_d = mode_q;
    if (mode_rise && !alarm_active(alarm_q)) begin
      case (mode_q)
        MRun:     mode_d = MSetTime;
        MSetTime: mode_d = MSetAlarm;
        default:  mode_d = MRun;
      endcase
    end
    mode_change = (mode_d != mode_q);
  end

  // Requests are held until a tick edge lands after >= 6 high cycles, so the core's
  // 3-flop input delay sees exactly one tick with the request asserted.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      inc_d[i] = inc_q[i];
      if (inc_q[i]) begin
        if (tick_rise && (age_q[i] >= 3'd6)) inc_d[i] = 1'b0;
      end else if (req_rise[i] && (mode_q != MRun)) begin
        inc_d[i] = 1'b1;
      end
      if (mode_change) inc_d[i] = 1'b0;

      if (!inc_d[i])              age_d[i] = 3'd0;
      else if (!inc_q[i])         age_d[i] = 3'd1;
      else if (age_q[i] != 3'd7)  age_d[i] = age_q[i] + 3'd1;
      else                        age_d[i] = age_q[i];
    end
  end

  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (!sw_lvl || mode_change) begin
      alarm_d = AIdle;
    end else if (mode_rise && alarm_active(alarm_q)) begin
      alarm_d = AIdle;
    end else if ((alarm_q == ARing) && snooze_rise) begin
`ifdef CLOCK_SNOOZE_EN
      alarm_d = ASnooze;
      acnt_d  = '0;
`else
      alarm_d = AIdle;
`endif
    end else begin
      case (alarm_q)
        ARing: begin
          if (tick_rise) begin
            if (acnt_q == RingLast) alarm_d = AIdle;
            else                    acnt_d  = acnt_q + 16'd1;
          end
        end
`ifdef CLOCK_SNOOZE_EN
        ASnooze: begin
          if (tick_rise) begin
            if (acnt_q == SnoozeLast) begin
              alarm_d = ARing;
              acnt_d  = '0;
            end else begin
              acnt_d  = acnt_q + 16'd1;
            end
          end
        end
`endif
        default: begin
          if (tick_rise && time_match && (mode_q == MRun)) begin
            alarm_d = ARing;
            acnt_d  = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    set_alarm_d = (mode_d == MSetAlarm);
    buzzer_d    = (alarm_d == ARing) && tick_lvl;
    led_d       = alarm_active(alarm_d);
  end

  assign bus.mode      = mode_q;
  assign bus.set_alarm = set_alarm_q;
  assign bus.inc_hr    = inc_q[1];
  assign bus.inc_min   = inc_q[0];
  assign bus.buzzer    = buzzer_q;
  assign bus.alarm_led = led_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller (RING_SECONDS=4, SNOOZE_SECONDS=3).
// Snooze expectations follow CLOCK_SNOOZE_EN when defined.
module tb_clock_mode_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  clock_mode_controller_if bus ();

  clock_mode_controller #(
    .RING_SECONDS  (4),
    .SNOOZE_SECONDS(3)
  ) dut (
    .clk_100MHz(clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  // Core model: 3-flop delayed tick and requests; one increment per delayed tick edge.
  logic [3:0] ctk = '0;
  logic [2:0] cmn = '0;
  logic [2:0] chr = '0;
  int core_min = 0;
  int core_hr = 0;
  always @(posedge clk) begin
    ctk <= {ctk[2:0], bus.tick_1Hz};
    cmn <= {cmn[1:0], bus.inc_min};
    chr <= {chr[1:0], bus.inc_hr};
    if (ctk[2] && !ctk[3]) begin
      if (cmn[2]) core_min <= core_min + 1;
      if (chr[2]) core_hr <= core_hr + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_mode = v;
      1: bus.btn_hr = v;
      2: bus.btn_min = v;
      default: bus.btn_snooze = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cycles(6);
    set_btn(b, 1'b0);
    cycles(6);
  endtask

  task automatic tick_hi(input int half);
    bus.tick_1Hz = 1'b1;
    cycles(half);
  endtask

  task automatic tick_lo(input int half);
    bus.tick_1Hz = 1'b0;
    cycles(half);
  endtask

  task automatic tick(input int half);
    tick_hi(half);
    tick_lo(half);
  endtask

  task automatic set_sec(input logic [3:0] s10, input logic [3:0] s1);
    bus.sec_10s = s10;
    bus.sec_1s  = s1;
  endtask

  task automatic ring_now();
    set_sec(4'd0, 4'd0);
    tick_hi(6);
    set_sec(4'd0, 4'd1);
    tick_lo(6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    bus.tick_1Hz = 0; bus.btn_mode = 0; bus.btn_hr = 0; bus.btn_min = 0;
    bus.btn_snooze = 0; bus.alarm_sw = 0;
    bus.hr_10s = 0; bus.hr_1s = 0; bus.min_10s = 0; bus.min_1s = 0;
    bus.sec_10s = 0; bus.sec_1s = 0;
    bus.alarm_hr_10s = 0; bus.alarm_hr_1s = 6; bus.alarm_min_10s = 3; bus.alarm_min_1s = 0;

    cycles(3);
    check("rst_mode", bus.mode, 0);
    check("rst_set_alarm", bus.set_alarm, 0);
    check("rst_inc_hr", bus.inc_hr, 0);
    check("rst_inc_min", bus.inc_min, 0);
    check("rst_buzzer", bus.buzzer, 0);
    check("rst_alarm_led", bus.alarm_led, 0);
    reset_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cycles(1);
      if ({bus.mode, bus.set_alarm, bus.inc_hr, bus.inc_min, bus.buzzer, bus.alarm_led} !== '0)
        bad++;
    end
    check("idle_1000_cycles", bad, 0);

    // Hour button in RUN is ignored
    bus.btn_hr = 1'b1;
    cycles(10);
    check("run_ignores_hr", bus.inc_hr, 0);
    bus.btn_hr = 1'b0;
    cycles(6);

    press(0);
    check("mode_set_time", bus.mode, 1);
    check("set_alarm_in_set_time", bus.set_alarm, 0);

    // One long minute press with an 8-cycle tick
    bus.btn_min = 1'b1;
    cycles(10);
    check("inc_min_raised", bus.inc_min, 1);
    tick(4);
    check("inc_min_dropped", bus.inc_min, 0);
    repeat (24) tick(4);
    bus.btn_min = 1'b0;
    cycles(10);
    check("inc_min_low_after", bus.inc_min, 0);
    check("core_min_one_step", core_min, 1);

    // Second hour press while request pending must not add a second increment
    press(1);
    check("inc_hr_raised", bus.inc_hr, 1);
    check("inc_min_independent", bus.inc_min, 0);
    press(1);
    check("inc_hr_still_high", bus.inc_hr, 1);
    repeat (3) tick(4);
    check("inc_hr_dropped", bus.inc_hr, 0);
    check("core_hr_one_step", core_hr, 1);

    // Pending request is cleared by a mode change
    press(2);
    check("inc_min_pending", bus.inc_min, 1);
    press(0);
    check("mode_set_alarm", bus.mode, 2);
    check("set_alarm_high", bus.set_alarm, 1);
    check("mode_change_clears_inc", bus.inc_min, 0);
    press(0);
    check("mode_run", bus.mode, 0);
    check("set_alarm_low", bus.set_alarm, 0);

    // Alarm: 06:29:59 -> 06:30:00
    bus.alarm_sw = 1'b1;
    bus.hr_1s = 6; bus.min_10s = 2; bus.min_1s = 9; set_sec(4'd5, 4'd9);
    tick(6);
    check("no_ring_at_062959", bus.alarm_led, 0);
    bus.min_10s = 3; bus.min_1s = 0; set_sec(4'd0, 4'd0);
    tick_hi(6);
    check("ring_led", bus.alarm_led, 1);
    check("ring_buzzer_tick_high", bus.buzzer, 1);
    set_sec(4'd0, 4'd1);
    tick_lo(6);
    check("ring_buzzer_tick_low", bus.buzzer, 0);
    check("ring_led_tick_low", bus.alarm_led, 1);
    repeat (3) tick(6);
    check("ring_before_timeout", bus.alarm_led, 1);
    tick_hi(6);
    check("ring_timeout_led", bus.alarm_led, 0);
    check("ring_timeout_buzzer", bus.buzzer, 0);
    tick_lo(6);

    // Mode press cancels ringing, mode unchanged
    ring_now();
    check("cancel_setup_ringing", bus.alarm_led, 1);
    press(0);
    check("cancel_led", bus.alarm_led, 0);
    check("cancel_mode_stays_run", bus.mode, 0);

    // Snooze
    ring_now();
    press(3);
`ifdef CLOCK_SNOOZE_EN
    check("snooze_led", bus.alarm_led, 1);
    check("snooze_buzzer", bus.buzzer, 0);
    tick(6);
    tick_hi(6);
    check("snooze_quiet_tick2", bus.buzzer, 0);
    tick_lo(6);
    tick_hi(6);
    check("snooze_resume_buzzer", bus.buzzer, 1);
    check("snooze_resume_led", bus.alarm_led, 1);
    tick_lo(6);
    press(0);
    check("snooze_cancelled", bus.alarm_led, 0);
`else
    check("snooze_off_led", bus.alarm_led, 0);
    check("snooze_off_buzzer", bus.buzzer, 0);
`endif

    // alarm_sw falls on the match tick
    set_sec(4'd0, 4'd0);
    bus.alarm_sw = 1'b0;
    tick_hi(6);
    check("sw_drop_on_match", bus.alarm_led, 0);
    set_sec(4'd0, 4'd1);
    tick_lo(6);
    bus.alarm_sw = 1'b1;
    cycles(4);

    // alarm_sw drop while ringing
    ring_now();
    check("sw_setup_ringing", bus.alarm_led, 1);
    bus.alarm_sw = 1'b0;
    cycles(5);
    check("sw_drop_forces_idle", bus.alarm_led, 0);

    // Asynchronous reset mid-request
    press(0);
    bus.btn_hr = 1'b1;
    cycles(6);
    check("pre_reset_inc_hr", bus.inc_hr, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_inc_hr", bus.inc_hr, 0);
    check("async_reset_mode", bus.mode, 0);
    bus.btn_hr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) tick(4);
    check("no_inc_after_reset", bus.inc_hr, 0);
    check("core_hr_unchanged", core_hr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
